aes_ctrl_seq: RTL and testbench
===============================

Name: aes_ctrl_seq

Overview:
- Sequencer half of the AES-128 core controller.
- Samples start/mode commands, counts rounds and drives the 4-bit state code Q consumed by the existing state-to-control-signal decoder.
- Holds the state register, next-state logic and round counter, so the decoder stays purely combinational.
- Q encodings are shared with that decoder and must not change.

Parameters:
NR, 10, total AES rounds; legal range 2..15.
QW, 4, width of state code Q; fixed at 4.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin operation; sampled only in S0
mode  input  1  0 = encrypt, 1 = decrypt; sampled together with start
hold  input  1  stall; freezes state and round while high
Q  output  4  state code to control decoder
round  output  4  current round index, used for key-expansion rcon
busy  output  1  high whenever Q != S0
done  output  1  high exactly while Q is S8 or S9

Behaviour:
- Encodings: S0=0000 idle, S1=0001 enc load, S2=0010 enc middle round, S3=0011 enc final round, S4=0100 dec load, S5=0101 dec first round, S6=0110 dec middle round, S7=0111 dec final round, S8=1000 enc output, S9=1001 dec output.
- Reset: async assert forces Q=S0, round=0, done=0, busy=0 immediately. This applies mid-operation too; no partial result is flagged.
- All registers update on the rising clk edge; outputs are registered (done and busy are decoded from the registered Q/round only, glitch-free).
- hold=1: Q, round and latched mode keep their values. In S0, start is ignored while hold=1. hold has priority over every transition except rst.
- Transitions, with hold=0:
  - S0: stay while start=0. start=1 and mode=0 -> S1. start=1 and mode=1 -> S4. Mode is latched internally at this edge.
  - S1 -> S2, round<=1.
  - S2: if round < NR-1 then stay, round<=round+1. Else -> S3, round<=NR.
  - S3 -> S8.
  - S8 -> S0, round<=0.
  - S4 -> S5, round<=1.
  - S5: if NR-1 > 1 then -> S6, round<=2. Else (NR=2) -> S7, round<=NR.
  - S6: if round < NR-1 then stay, round<=round+1. Else -> S7, round<=NR.
  - S7 -> S9.
  - S9 -> S0, round<=0.
- round is 0 in S0, S1 and S4, and holds NR through S3/S8 and S7/S9.
- Latency, NR=10, start edge = edge 0:
  - Encrypt: S1@e0, S2@e1..e9 (rounds 1..9), S3@e10, S8@e11, S0@e12.
  - Decrypt: S4@e0, S5@e1, S6@e2..e9, S7@e10, S9@e11, S0@e12.
  - Both take NR+2 cycles from start to idle.
- start or mode changes while busy are ignored; no queueing.
- start asserted in the same cycle that Q returns to S0 is accepted on the next edge; back-to-back operations have one idle cycle between them.
- Illegal Q (1010..1111, e.g. from an SEU): next edge -> S0, round<=0; done stays 0.
- round never exceeds NR and never wraps.

Test Plan:
- Reset: assert rst mid-clock with no clk edge -> Q=0000, round=0, busy=0, done=0 immediately. Release rst, start=0 for 5 cycles -> Q stays 0000.
- Encrypt NR=10: start=1, mode=0 for one cycle -> Q sequence 1, 2×9 (round 1..9), 3 (round 10), 8 (done=1), 0. busy high for exactly 12 cycles.
- Decrypt NR=10: start=1, mode=1 -> Q sequence 4, 5 (round 1), 6×8 (round 2..9), 7 (round 10), 9 (done=1), 0.
- Hold: hold=1 for 3 cycles while Q=S2, round=4 -> Q=2 and round=4 unchanged. Operation then completes with the total cycle count extended by exactly 3.
- Ignored commands: pulse start with mode=1 during an encrypt in S2 -> sequence unaltered, ends in S8 not S9. start held continuously -> a new operation begins one cycle after S0 is reached.
- Mid-op reset and NR=2 corner: rst during S6 -> Q=0 asynchronously, done never pulses. With NR=2, decrypt runs S4, S5, S7, S9, S0 and encrypt runs S1, S2, S3, S8, S0.

Source files
------------

// File: rtl/aes_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_ctrl_seq
// Purpose  : AES-128 controller sequencer; state code Q and round counter
//            for the combinational state-to-control decoder.
// Revision : 1.0 - initial release
// ============================================================================
module aes_ctrl_seq #(
    parameter int NR = 10,
    parameter int QW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic          hold,
    output logic [QW-1:0] Q,
    output logic [3:0]    round,
    output logic          busy,
    output logic          done
);

    // Encodings are shared with the downstream decoder and must stay fixed.
    typedef enum logic [3:0] {
        S0 = 4'b0000,
        S1 = 4'b0001,
        S2 = 4'b0010,
        S3 = 4'b0011,
        S4 = 4'b0100,
        S5 = 4'b0101,
        S6 = 4'b0110,
        S7 = 4'b0111,
        S8 = 4'b1000,
        S9 = 4'b1001
    } state_t;

    localparam logic [3:0] c_last = 4'(NR - 1);
    localparam logic [3:0] c_nr   = 4'(NR);

    generate
        if (NR < 2 || NR > 15 || QW != 4) begin : g_bad_param
            $error("aes_ctrl_seq: NR must be 2..15 and QW must be 4");
        end
    endgenerate

    state_t     r_state;
    logic [3:0] r_round;

    // The load state (S1/S4) itself records the sampled mode for the
    // whole operation, so no separate mode flop is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S0;
            r_round <= 4'd0;
        end else if (!hold) begin
            case (r_state)
                S0: begin
                    r_round <= 4'd0;
                    if (start) begin
                        r_state <= mode ? S4 : S1;
                    end
                end
                S1: begin
                    r_state <= S2;
                    r_round <= 4'd1;
                end
                S2: begin
                    if (r_round < c_last) begin
                        r_round <= r_round + 4'd1;
                    end else begin
                        r_state <= S3;
                        r_round <= c_nr;
                    end
                end
                S3: r_state <= S8;
                S8: begin
                    r_state <= S0;
                    r_round <= 4'd0;
                end
                S4: begin
                    r_state <= S5;
                    r_round <= 4'd1;
                end
                S5: begin
                    if (c_last > 4'd1) begin
                        r_state <= S6;
                        r_round <= 4'd2;
                    end else begin
                        r_state <= S7;
                        r_round <= c_nr;
                    end
                end
                S6: begin
                    if (r_round < c_last) begin
                        r_round <= r_round + 4'd1;
                    end else begin
                        r_state <= S7;
                        r_round <= c_nr;
                    end
                end
                S7: r_state <= S9;
                S9: begin
                    r_state <= S0;
                    r_round <= 4'd0;
                end
                // Unused codes (upset flops) recover to idle without a done pulse.
                default: begin
                    r_state <= S0;
                    r_round <= 4'd0;
                end
            endcase
        end
    end

    assign Q     = r_state;
    assign round = r_round;
    assign busy  = (r_state != S0);
    assign done  = (r_state == S8) || (r_state == S9);

endmodule
`default_nettype wire

// File: tb/tb_aes_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_ctrl_seq
// Purpose  : Self-checking bench for aes_ctrl_seq (NR=10 and NR=2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] q0, q1, r0, r1;
    logic       busy0, busy1, done0, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_ctrl_seq #(.NR(10), .QW(4)) u_dut10 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .hold(hold),
        .Q(q0), .round(r0), .busy(busy0), .done(done0)
    );

    aes_ctrl_seq #(.NR(2), .QW(4)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .hold(hold),
        .Q(q1), .round(r1), .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Expected outputs from the operation's mode and its count k of
    // non-stalled edges since the start edge (k=0 is the load state).
    function automatic void model_out(input int nr, input bit md, input bit act, input int k,
                                      output logic [3:0] q, output logic [3:0] r);
        if (!act) begin
            q = 4'd0; r = 4'd0;
        end else if (k == 0) begin
            q = md ? 4'd4 : 4'd1; r = 4'd0;
        end else if (k == nr + 1) begin
            q = md ? 4'd9 : 4'd8; r = 4'(nr);
        end else if (k == nr) begin
            q = md ? 4'd7 : 4'd3; r = 4'(nr);
        end else if (md && k == 1) begin
            q = 4'd5; r = 4'd1;
        end else begin
            q = md ? 4'd6 : 4'd2; r = 4'(k);
        end
    endfunction

    int  m_nr [2] = '{10, 2};
    bit  m_act[2];
    bit  m_md [2];
    int  m_k  [2];

    always @(posedge clk or posedge rst) begin
        logic [3:0] eq, er;
        logic [3:0] aq, ar;
        logic       ab, ad;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] = 1'b0;
                m_k[i]   = 0;
            end else if (m_act[i]) begin
                if (!hold) begin
                    m_k[i]++;
                    if (m_k[i] == m_nr[i] + 2) m_act[i] = 1'b0;
                end
            end else if (!hold && start) begin
                m_act[i] = 1'b1;
                m_k[i]   = 0;
                m_md[i]  = mode;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            model_out(m_nr[i], m_md[i], m_act[i], m_k[i], eq, er);
            aq = (i == 0) ? q0 : q1;
            ar = (i == 0) ? r0 : r1;
            ab = (i == 0) ? busy0 : busy1;
            ad = (i == 0) ? done0 : done1;
            check($sformatf("dut%0d_Q", i), 32'(aq), 32'(eq));
            check($sformatf("dut%0d_round", i), 32'(ar), 32'(er));
            check($sformatf("dut%0d_busy", i), 32'(ab), 32'(m_act[i]));
            check($sformatf("dut%0d_done", i), 32'(ad),
                  32'(m_act[i] && m_k[i] == m_nr[i] + 1));
        end
    end

    int         cnt0, cnt1;
    logic [3:0] seq0[32];
    logic [3:0] seq1[32];

    // One operation; counts busy cycles of each instance, optionally stalls
    // three cycles at Q=S2/round=4 or pulses a decrypt start at round 2.
    task automatic run_op(input bit md, input bit do_hold, input bit do_pulse);
        bit hdone = 1'b0;
        int guard = 0;
        @(negedge clk);
        start = 1'b1; mode = md;
        @(negedge clk);
        start = 1'b0;
        cnt0 = 0; cnt1 = 0;
        while (busy0 && guard < 60) begin
            guard++;
            seq0[cnt0 % 32] = q0; cnt0++;
            if (busy1) begin seq1[cnt1 % 32] = q1; cnt1++; end
            start = 1'b0;
            if (do_pulse && q0 == 4'd2 && r0 == 4'd2) begin
                start = 1'b1; mode = 1'b1;
            end
            if (do_hold && !hdone && q0 == 4'd2 && r0 == 4'd4) begin
                hdone = 1'b1;
                hold  = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    seq0[cnt0 % 32] = q0; cnt0++;
                end
                hold = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("op_timeout", 32'(guard < 60), 32'd1);
    endtask

    initial begin
        logic [3:0] tq, tr;
        logic [3:0] enc_seq[13];
        enc_seq = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2,
                    4'd3, 4'd8, 4'd0};

        // Hand-computed points of the reference model.
        model_out(10, 1'b0, 1'b1, 5, tq, tr);  check("model_enc_k5", {tq, tr}, 8'h25);
        model_out(10, 1'b1, 1'b1, 1, tq, tr);  check("model_dec_k1", {tq, tr}, 8'h51);
        model_out(2, 1'b1, 1'b1, 2, tq, tr);   check("model_nr2_dec_k2", {tq, tr}, 8'h72);
        model_out(10, 1'b1, 1'b1, 11, tq, tr); check("model_dec_k11", {tq, tr}, 8'h9A);

        // Reset asserted between clock edges must take effect immediately.
        #2 rst = 1'b1;
        #1;
        check("rst_async_Q", 32'(q0), 32'd0);
        check("rst_async_busy", 32'(busy0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_Q", 32'(q0), 32'd0);

        // Encrypt: literal sequence of the NR=10 instance.
        run_op(1'b0, 1'b0, 1'b0);
        check("enc_busy_cycles", 32'(cnt0), 32'd12);
        check("enc_nr2_busy_cycles", 32'(cnt1), 32'd4);
        for (int j = 0; j < 12; j++) check($sformatf("enc_seq%0d", j), 32'(seq0[j]), 32'(enc_seq[j]));
        check("enc_end_idle", 32'(q0), 32'(enc_seq[12]));
        check("enc_nr2_seq", {seq1[0], seq1[1], seq1[2], seq1[3]}, 16'h1238);

        // Decrypt.
        run_op(1'b1, 1'b0, 1'b0);
        check("dec_busy_cycles", 32'(cnt0), 32'd12);
        check("dec_first", {seq0[0], seq0[1], seq0[2]}, 12'h456);
        check("dec_last", {seq0[9], seq0[10], seq0[11]}, 12'h679);
        check("dec_nr2_seq", {seq1[0], seq1[1], seq1[2], seq1[3]}, 16'h4579);

        // Stall extends the operation by exactly the stalled cycles.
        run_op(1'b0, 1'b1, 1'b0);
        check("hold_busy_cycles", 32'(cnt0), 32'd15);
        check("hold_frozen", {seq0[4], seq0[5], seq0[6], seq0[7]}, 16'h2222);

        // A start/mode pulse mid-encrypt is ignored.
        run_op(1'b0, 1'b0, 1'b1);
        check("pulse_busy_cycles", 32'(cnt0), 32'd12);
        check("pulse_ends_s8", 32'(seq0[11]), 32'd8);

        // Start held continuously: back-to-back operations.
        @(negedge clk);
        start = 1'b1; mode = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);

        // Mid-operation reset during S6.
        start = 1'b1; mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 20 && q0 != 4'd6; g++) @(negedge clk);
        check("reach_s6", 32'(q0), 32'd6);
        #2 rst = 1'b1;
        #1;
        check("midop_rst_Q", 32'(q0), 32'd0);
        check("midop_rst_done", 32'(done0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with occasional stalls and resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            mode  = 1'($urandom);
            hold  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
            end else begin
                rst = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0; hold = 1'b0; rst = 1'b0;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
